// File: rtl/cnt5_pkg.sv
// Shared constants for the 5-way one-hot counter and its monitor: positions,
// monitor FSM states, fault codes and mod-5 position helpers.
package cnt5_pkg;

  localparam logic [4:0] ZERO  = 5'b00001;
  localparam logic [4:0] ONE   = 5'b00010;
  localparam logic [4:0] TWO   = 5'b00100;
  localparam logic [4:0] THREE = 5'b01000;
  localparam logic [4:0] FOUR  = 5'b10000;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] ENC  = 2'b01;
  localparam logic [1:0] JUMP = 2'b10;

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [2:0] pos_dec(input logic [2:0] p);
    return (p == 3'd0) ? 3'd4 : p - 3'd1;
  endfunction

endpackage

// File: rtl/cnt5_monitor_if.sv
// Sample/status bundle between a one-hot counter source and cnt5_monitor.
interface cnt5_monitor_if #(parameter int REV_W = 8);
  logic [4:0]       cnt;
  logic             cnt_vld;
  logic             err_clr;
  logic [2:0]       pos;
  logic             pos_vld;
  logic             dir;
  logic             step;
  logic [REV_W-1:0] rev_up;
  logic [REV_W-1:0] rev_dn;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output cnt, cnt_vld, err_clr,
    input  pos, pos_vld, dir, step, rev_up, rev_dn, err, err_code
  );

  modport slave (
    input  cnt, cnt_vld, err_clr,
    output pos, pos_vld, dir, step, rev_up, rev_dn, err, err_code
  );
endinterface

// File: rtl/cnt5_monitor_dec.sv
// onehot5_dec: combinational one-hot to binary index decode with legality flag.
module onehot5_dec
  import cnt5_pkg::*;
(
  input  logic [4:0] i_oh,
  output logic [2:0] o_idx,
  output logic       o_legal
);

  always_comb begin
    o_idx   = 3'd0;
    o_legal = 1'b1;
    case (i_oh)
      ZERO:    o_idx = 3'd0;
      ONE:     o_idx = 3'd1;
      TWO:     o_idx = 3'd2;
      THREE:   o_idx = 3'd3;
      FOUR:    o_idx = 3'd4;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cnt5_monitor.sv
// Tracks a 5-way one-hot counter, classifies steps and latches sticky faults.
// Define CNT5_MON_REV_EN to build the up/down revolution counters.
module cnt5_monitor
  import cnt5_pkg::*;
#(
  parameter int REV_W   = 8,
  parameter bit HOLD_OK = 1'b1
) (
  input  logic           clk,
  input  logic           rb,
  cnt5_monitor_if.slave  m
);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_pos, w_pos_nxt, w_p;
  logic       w_legal;
  logic       r_dir, w_dir_nxt;
  logic       r_step, w_step_nxt;
  logic [1:0] r_code, w_code_nxt;
  logic       w_track_smp, w_hit_hold, w_hit_up, w_hit_dn;

  onehot5_dec u_dec (
    .i_oh    (m.cnt),
    .o_idx   (w_p),
    .o_legal (w_legal)
  );

  assign w_track_smp = (r_state == TRACK) && m.cnt_vld && w_legal;
  assign w_hit_hold  = w_track_smp && (w_p == r_pos);
  assign w_hit_up    = w_track_smp && (w_p == pos_inc(r_pos));
  assign w_hit_dn    = w_track_smp && (w_p == pos_dec(r_pos));

  always_ff @(posedge clk or posedge rb) begin
    if (rb) r_state <= INIT;
    else    r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (m.cnt_vld) w_state_nxt = w_legal ? TRACK : FAULT;
      TRACK:   if (m.cnt_vld && !(w_hit_up || w_hit_dn || (w_hit_hold && HOLD_OK)))
                 w_state_nxt = FAULT;
      // clear beats a coincident sample, which is simply dropped
      FAULT:   if (m.err_clr) w_state_nxt = INIT;
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_code_nxt = r_code;
    case (r_state)
      INIT: begin
        if (m.cnt_vld) begin
          if (w_legal) w_pos_nxt  = w_p;
          else         w_code_nxt = ENC;
        end
      end
      TRACK: begin
        if (m.cnt_vld) begin
          if (!w_legal) begin
            w_code_nxt = ENC;
          end else if (w_hit_up || w_hit_dn) begin
            w_pos_nxt  = w_p;
            w_dir_nxt  = w_hit_up;
            w_step_nxt = 1'b1;
          end else if (!(w_hit_hold && HOLD_OK)) begin
            w_code_nxt = JUMP;
          end
        end
      end
      FAULT:   if (m.err_clr) w_code_nxt = NONE;
      default: w_code_nxt = r_code;
    endcase
  end

  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      r_pos  <= 3'd0;
      r_dir  <= 1'b1;
      r_step <= 1'b0;
      r_code <= NONE;
    end else begin
      r_pos  <= w_pos_nxt;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
      r_code <= w_code_nxt;
    end
  end

`ifdef CNT5_MON_REV_EN
  logic [REV_W-1:0] r_rev_up, r_rev_dn;
  logic             w_wrap_up, w_wrap_dn;

  assign w_wrap_up = w_hit_up && (r_pos == 3'd4);
  assign w_wrap_dn = w_hit_dn && (r_pos == 3'd0);

  // only rb clears the revolution history; fault clears leave it intact
  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      r_rev_up <= '0;
      r_rev_dn <= '0;
    end else begin
      if (w_wrap_up) r_rev_up <= r_rev_up + REV_W'(1);
      if (w_wrap_dn) r_rev_dn <= r_rev_dn + REV_W'(1);
    end
  end

  assign m.rev_up = r_rev_up;
  assign m.rev_dn = r_rev_dn;
`else
  assign m.rev_up = '0;
  assign m.rev_dn = '0;
`endif

  assign m.pos      = r_pos;
  assign m.pos_vld  = (r_state == TRACK);
  assign m.dir      = r_dir;
  assign m.step     = r_step;
  assign m.err      = (r_state == FAULT);
  assign m.err_code = r_code;

endmodule

// File: tb/tb_cnt5_monitor.sv
// Directed table-driven check of cnt5_monitor (default and HOLD_OK=0/REV_W=2 builds).
module tb_cnt5_monitor;
  import cnt5_pkg::*;

`ifdef CNT5_MON_REV_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rb_a, rb_b;
  always #5 clk = ~clk;

  cnt5_monitor_if #(.REV_W(8)) ifa ();
  cnt5_monitor_if #(.REV_W(2)) ifb ();

  cnt5_monitor #(.REV_W(8), .HOLD_OK(1'b1)) dut_a (.clk(clk), .rb(rb_a), .m(ifa));
  cnt5_monitor #(.REV_W(2), .HOLD_OK(1'b0)) dut_b (.clk(clk), .rb(rb_b), .m(ifb));

  typedef struct {
    logic [4:0] cnt;
    int vld, clr;
    int pos, pv, dir, stp, err, code, ru, rd;
  } vec_t;

  vec_t tv[23];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input vec_t e);
    chk({tag, ".pos"},      32'(ifa.pos),      e.pos);
    chk({tag, ".pos_vld"},  32'(ifa.pos_vld),  e.pv);
    chk({tag, ".dir"},      32'(ifa.dir),      e.dir);
    chk({tag, ".step"},     32'(ifa.step),     e.stp);
    chk({tag, ".err"},      32'(ifa.err),      e.err);
    chk({tag, ".err_code"}, 32'(ifa.err_code), e.code);
    chk({tag, ".rev_up"},   32'(ifa.rev_up),   REV_EN ? e.ru : 0);
    chk({tag, ".rev_dn"},   32'(ifa.rev_dn),   REV_EN ? e.rd : 0);
  endtask

  task automatic drv_a(input logic [4:0] c, input logic v, input logic cl);
    @(negedge clk);
    ifa.cnt = c; ifa.cnt_vld = v; ifa.err_clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_b(input logic [4:0] c, input logic v, input logic cl);
    @(negedge clk);
    ifb.cnt = c; ifb.cnt_vld = v; ifb.err_clr = cl;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] c, input int v, input int cl,
                              input int p, input int pv, input int d, input int s,
                              input int e, input int cd, input int ru, input int rd);
    vec_t t;
    t.cnt = c; t.vld = v; t.clr = cl; t.pos = p; t.pv = pv; t.dir = d;
    t.stp = s; t.err = e; t.code = cd; t.ru = ru; t.rd = rd;
    return t;
  endfunction

  initial begin
    vec_t rst_v;
    logic [4:0] oh;
    //            cnt       v  c  pos pv dir stp err code ru rd
    tv[0]  = mk(5'b00001, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tv[1]  = mk(5'b00010, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    tv[2]  = mk(5'b00100, 1, 0, 2, 1, 1, 1, 0, 0, 0, 0);
    tv[3]  = mk(5'b01000, 1, 0, 3, 1, 1, 1, 0, 0, 0, 0);
    tv[4]  = mk(5'b10000, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0);
    tv[5]  = mk(5'b00001, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    tv[6]  = mk(5'b10000, 1, 0, 4, 1, 0, 1, 0, 0, 1, 1);
    tv[7]  = mk(5'b00001, 1, 0, 0, 1, 1, 1, 0, 0, 2, 1);
    tv[8]  = mk(5'b00100, 0, 0, 0, 1, 1, 0, 0, 0, 2, 1);
    tv[9]  = mk(5'b00001, 1, 0, 0, 1, 1, 0, 0, 0, 2, 1);
    tv[10] = mk(5'b00011, 1, 0, 0, 0, 1, 0, 1, 1, 2, 1);
    tv[11] = mk(5'b00010, 1, 0, 0, 0, 1, 0, 1, 1, 2, 1);
    tv[12] = mk(5'b00000, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
    tv[13] = mk(5'b00001, 1, 0, 0, 1, 1, 0, 0, 0, 2, 1);
    tv[14] = mk(5'b00010, 0, 1, 0, 1, 1, 0, 0, 0, 2, 1);
    tv[15] = mk(5'b00100, 1, 0, 0, 0, 1, 0, 1, 2, 2, 1);
    tv[16] = mk(5'b00010, 1, 1, 0, 0, 1, 0, 0, 0, 2, 1);
    tv[17] = mk(5'b01000, 1, 0, 3, 1, 1, 0, 0, 0, 2, 1);
    tv[18] = mk(5'b00100, 1, 0, 2, 1, 0, 1, 0, 0, 2, 1);
    tv[19] = mk(5'b00000, 1, 0, 2, 0, 0, 0, 1, 1, 2, 1);
    tv[20] = mk(5'b00000, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1);
    tv[21] = mk(5'b11000, 1, 0, 2, 0, 0, 0, 1, 1, 2, 1);
    tv[22] = mk(5'b00000, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1);
    rst_v  = mk(5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    rb_a = 1'b1; rb_b = 1'b1;
    ifa.cnt = '0; ifa.cnt_vld = 1'b0; ifa.err_clr = 1'b0;
    ifb.cnt = '0; ifb.cnt_vld = 1'b0; ifb.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", rst_v);
    @(negedge clk);
    rb_a = 1'b0;

    for (int i = 0; i < 23; i++)
      drv_a(tv[i].cnt, 1'(tv[i].vld), 1'(tv[i].clr));
      // checked right after each edge in the loop below
    // (loop above only streams; re-run with checks interleaved)
    rb_a = 1'b1;
    @(negedge clk);
    rb_a = 1'b0;
    for (int i = 0; i < 23; i++) begin
      drv_a(tv[i].cnt, 1'(tv[i].vld), 1'(tv[i].clr));
      chk_a($sformatf("vec%0d", i), tv[i]);
    end

    // asynchronous reset in the middle of a stream
    drv_a(5'b01000, 1'b1, 1'b0);
    drv_a(5'b10000, 1'b1, 1'b0);
    chk("mid.step_before_rb", 32'(ifa.step), 1);
    @(negedge clk);
    ifa.cnt_vld = 1'b0;
    rb_a = 1'b1;
    #1;
    chk_a("async_rb", rst_v);
    #2;
    rb_a = 1'b0;
    drv_a(5'b00100, 1'b1, 1'b0);
    chk_a("post_rb_init", mk(5'b00100, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
    drv_a(5'b00000, 1'b0, 1'b0);

    // HOLD_OK=0 build: a repeated sample is a jump fault
    rb_b = 1'b0;
    drv_b(5'b00010, 1'b1, 1'b0);
    chk("b.init_pos", 32'(ifb.pos), 1);
    chk("b.init_pv",  32'(ifb.pos_vld), 1);
    drv_b(5'b00010, 1'b1, 1'b0);
    chk("b.hold_err",  32'(ifb.err), 1);
    chk("b.hold_code", 32'(ifb.err_code), 2);
    chk("b.hold_pv",   32'(ifb.pos_vld), 0);
    chk("b.hold_step", 32'(ifb.step), 0);
    drv_b(5'b00000, 1'b0, 1'b1);
    chk("b.clr_err",  32'(ifb.err), 0);
    chk("b.clr_code", 32'(ifb.err_code), 0);

    // REV_W=2: four up-revolutions wrap the counter back to 0
    drv_b(5'b00001, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 1; k < 5; k++) begin
        oh = 5'b00001 << k;
        drv_b(oh, 1'b1, 1'b0);
      end
      drv_b(5'b00001, 1'b1, 1'b0);
      chk($sformatf("b.rev%0d_step", r), 32'(ifb.step), 1);
      chk($sformatf("b.rev%0d_up", r), 32'(ifb.rev_up), REV_EN ? (r + 1) % 4 : 0);
    end
    chk("b.rev_dn", 32'(ifb.rev_dn), 0);
    chk("b.err_end", 32'(ifb.err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt5_monitor.md
# cnt5_monitor

- Downstream checker/tracker for the 5-way one-hot up/down counter.
- Samples the counter's one-hot `cnt` bus when qualified and converts it to a binary position.
- Classifies each sample-to-sample transition as step-up, step-down, hold or illegal, and counts wrap-around revolutions in each direction.
- Latches a sticky error on any illegal encoding or non-adjacent jump; used for debug visibility and fault detection next to the counter.

## Interface
Parameters:
- `REV_W`, default 8: width of each revolution counter.
- `HOLD_OK`, default 1: when 1, an unchanged sample is legal; when 0, it is a jump fault.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rb`  in  1  reset, asynchronous, active-high.
- `cnt`  in  5  one-hot position from the counter: bit0 = zero … bit4 = four.
- `cnt_vld`  in  1  sample qualifier for `cnt`.
- `err_clr`  in  1  clears a latched fault.
- `pos`  out  3  binary position 0..4.
- `pos_vld`  out  1  `pos` holds a tracked, legal value.
- `dir`  out  1  direction of last accepted step: 1 = up, 0 = down.
- `step`  out  1  one-cycle pulse per accepted step.
- `rev_up`  out  REV_W  count of four→zero up-wraps.
- `rev_dn`  out  REV_W  count of zero→four down-wraps.
- `err`  out  1  sticky fault flag.
- `err_code`  out  2  00 none, 01 illegal encoding, 10 illegal jump.

## Operation
- Legal encoding: exactly one bit of `cnt` set. Decoded position p = index of the set bit.
- Samples with `cnt_vld` = 0 are ignored in every state.
- FSM states: INIT, TRACK, FAULT.
- INIT (no reference sample held):
  - vld + legal → TRACK; `pos` = p; `pos_vld` = 1; no `step`; no rev change.
  - vld + illegal → FAULT; `err_code` = 01.
- TRACK, on a vld sample:
  - illegal encoding → FAULT, 01.
  - p == pos: if HOLD_OK, stay with no step; else FAULT, 10.
  - p == (pos+1) mod 5 → `step` = 1, `dir` = 1; if pos = 4 and p = 0, `rev_up`++.
  - p == (pos+4) mod 5 → `step` = 1, `dir` = 0; if pos = 0 and p = 4, `rev_dn`++.
  - any other p (distance 2 or 3) → FAULT, 10.
- FAULT:
  - `err` = 1; `pos_vld` = 0; `pos` frozen at last tracked value; samples ignored.
  - `err_clr` → INIT; `err` = 0 and `err_code` = 00 from the next cycle.
- `err_clr` outside FAULT has no effect.
- In FAULT, `err_clr` and `cnt_vld` in the same cycle: clear wins and the sample is discarded.
- Revolution counters wrap modulo 2^REV_W. Only `rb` clears them; `err_clr` does not.
- Position arithmetic is mod 5 on 3 bits; encodings 5..7 are never produced.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N.
- `step` is high for exactly one cycle per accepted step, so back-to-back vld samples give consecutive pulses.
- Fault detection latency is one cycle; `err` rises in the same cycle `pos_vld` falls.
- `rb` asserted at any time, mid-stream included, immediately forces the reset values:
  - state INIT
  - `pos` = 0, `pos_vld` = 0
  - `dir` = 1, `step` = 0
  - `rev_up` = `rev_dn` = 0
  - `err` = 0, `err_code` = 00
- The first vld sample after `rb` deasserts is treated as an INIT sample.

## Configuration
- Macro `CNT5_MON_REV_EN`:
  - Defined: `rev_up`/`rev_dn` registers and their increment logic are built as described above.
  - Undefined: no revolution registers are built, and both outputs are tied to 0. All other behaviour is identical.

## Structure
- Shared package `cnt5_pkg` holds:
  - one-hot position constants ZERO..FOUR (00001..10000)
  - FSM state encoding INIT/TRACK/FAULT
  - `err_code` constants NONE/ENC/JUMP
- The upstream counter uses the same constants.
- One sub-module, `onehot5_dec`: purely combinational; takes the 5-bit one-hot bus and outputs the 3-bit index plus a legal flag.

## Test plan
- Reset; vld samples 00001, 00010, 00100, 01000, 10000, 00001 → `pos` 0, 1, 2, 3, 4, 0; five `step` pulses; `dir` = 1; `rev_up` = 1.
- From TRACK at `pos` = 0, sample 10000 → `pos` = 4, `dir` = 0, `rev_dn` = 1, one `step`.
- In TRACK, sample 00011 → next cycle `err` = 1, `err_code` = 01, `pos_vld` = 0. Then `err_clr` → `err` = 0; next legal sample re-enters TRACK with no `step`.
- At `pos` = 0, sample 00100 → `err_code` = 10. Assert `err_clr` with `cnt_vld` in the same cycle → state INIT and that sample is ignored.
- Repeat sample 00010: HOLD_OK = 1 → no `step`, no error; HOLD_OK = 0 → `err_code` = 10.
- REV_W = 2: four full up-revolutions → `rev_up` wraps to 0. Assert `rb` mid-sequence → all outputs at reset values in the same cycle.
